bsg_credit_flow_sender: RTL

- Upstream partner of the credit-on-input small FIFO.
- Accepts a ready/valid stream from a producer and forwards it to the FIFO's v_i/data_i over a registered link.
- Tracks free FIFO slots with a credit counter, replenished by the FIFO's registered credit_o pulses.
- Never issues a word without a credit, so the FIFO cannot overflow regardless of link latency.

---
 rtl/bsg_credit_flow_pkg.sv | 24 ++
 rtl/bsg_credit_counter.sv | 57 +++++
 rtl/bsg_credit_flow_sender.sv | 95 +++++++++
 3 files changed

// File: rtl/bsg_credit_flow_pkg.sv
// ============================================================================
// Module  : bsg_credit_flow_pkg
// Brief   : Shared counter sizing helper and counter-update encoding for the
//           credit flow sender.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bsg_credit_flow_pkg;

    // Bits needed to hold every value from 0 up to and including credits.
    function automatic int cnt_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage

`default_nettype wire

// File: rtl/bsg_credit_counter.sv
// ============================================================================
// Module  : bsg_credit_counter
// Brief   : Saturating up/down counter. A simultaneous up and down cancel out,
//           and overflow_o flags an up request made while already at max.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_credit_counter
    import bsg_credit_flow_pkg::*;
#(
    parameter int  max_val_p    = 4,
    parameter int  init_val_p   = max_val_p,
    localparam int cnt_width_lp = cnt_width(max_val_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    up_i,
    input  logic                    down_i,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    overflow_o
);

    localparam logic [cnt_width_lp-1:0] c_max  = cnt_width_lp'(max_val_p);
    localparam logic [cnt_width_lp-1:0] c_init = cnt_width_lp'(init_val_p);
    localparam logic [cnt_width_lp-1:0] c_one  = cnt_width_lp'(1);

    logic [cnt_width_lp-1:0] r_count;
    cnt_op_e                 w_op;

    always_comb begin
        w_op = CNT_HOLD;
        if (up_i && !down_i) begin
            w_op = CNT_INC;
        end else if (down_i && !up_i) begin
            w_op = CNT_DEC;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= c_init;
        end else begin
            case (w_op)
                CNT_INC: if (r_count != c_max)     r_count <= r_count + c_one;
                CNT_DEC: if (r_count != '0)        r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count_o    = r_count;
    assign overflow_o = ~reset_i & (w_op == CNT_INC) & (r_count == c_max);

endmodule

`default_nettype wire

// File: rtl/bsg_credit_flow_sender.sv
// ============================================================================
// Module  : bsg_credit_flow_sender
// Brief   : Credit-based sender feeding a credit-on-input FIFO over a
//           registered link; never issues a word without a credit.
//           Optional overflow checker: BSG_CREDIT_FLOW_SENDER_OVERFLOW_CHECK_EN
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_credit_flow_sender
    import bsg_credit_flow_pkg::*;
#(
    parameter int  width_p      = 128,
    parameter int  credits_p    = 1000,
    localparam int cnt_width_lp = cnt_width(credits_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    credit_i,
    output logic [cnt_width_lp-1:0] credits_o,
    output logic                    error_o
);

    logic [cnt_width_lp-1:0] w_count;
    logic                    w_ready;
    logic                    w_send;
    logic                    r_v;
    logic [width_p-1:0]      r_data;

    // No credit bypass: a returning credit only raises ready next cycle.
    assign w_ready = ~reset_i & (w_count != '0);
    assign w_send  = v_i & w_ready;

`ifdef BSG_CREDIT_FLOW_SENDER_OVERFLOW_CHECK_EN
    logic w_overflow;
    logic r_error;
`endif

    bsg_credit_counter #(
        .max_val_p  (credits_p),
        .init_val_p (credits_p)
    ) u_credit_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .up_i       (credit_i),
        .down_i     (w_send),
        .count_o    (w_count),
`ifdef BSG_CREDIT_FLOW_SENDER_OVERFLOW_CHECK_EN
        .overflow_o (w_overflow)
`else
        .overflow_o ()
`endif
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v    <= 1'b0;
            r_data <= '0;
        end else begin
            r_v <= w_send;
            if (w_send) begin
                r_data <= data_i;
            end
        end
    end

`ifdef BSG_CREDIT_FLOW_SENDER_OVERFLOW_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_error <= 1'b0;
        end else if (w_overflow) begin
            r_error <= 1'b1;
`ifndef SYNTHESIS
            $error("bsg_credit_flow_sender: credit overflow at time %0t", $time);
`endif
        end
    end
    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

    assign ready_o   = w_ready;
    assign v_o       = r_v;
    assign data_o    = r_data;
    assign credits_o = w_count;

endmodule

`default_nettype wire
